// File: rtl/axis_peak_window.sv
// Windowed peak finder: picks the sample with the largest channel magnitude in each
// window of WINDOW_LEN accepted samples. Optional macro PEAK_THRESHOLD_EN adds a discard threshold.
module axis_peak_window #(
  parameter int NUM_CHANNELS  = 4,
  parameter int CHANNEL_WIDTH = 32,
  parameter int WINDOW_LEN    = 64,
  localparam int ABS_WIDTH = (CHANNEL_WIDTH <= 32) ? 16 : 32,
  localparam int IDX_WIDTH = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1,
  localparam int CH_WIDTH  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int BUS_W     = NUM_CHANNELS * CHANNEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [BUS_W-1:0]     s_axis_tdata,
  input  logic [BUS_W-1:0]     s_axis_tdata_abs,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [BUS_W-1:0]     m_axis_tdata,
  output logic [BUS_W-1:0]     m_axis_tdata_abs,
  output logic [IDX_WIDTH-1:0] m_axis_tindex,
  output logic [CH_WIDTH-1:0]  m_axis_tchan
`ifdef PEAK_THRESHOLD_EN
  ,
  input  logic [ABS_WIDTH-1:0] threshold
`endif
);

  typedef enum logic {SCAN, OUT} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(WINDOW_LEN - 1);

  state_t               state;
  logic [IDX_WIDTH-1:0] count;

  logic [BUS_W-1:0]     peak_data_p1;
  logic [BUS_W-1:0]     peak_abs_p1;
  logic [ABS_WIDTH-1:0] peak_metric_p1;
  logic [IDX_WIDTH-1:0] peak_idx_p1;
  logic [CH_WIDTH-1:0]  peak_chan_p1;

  logic                 vld_p0;
  logic [ABS_WIDTH-1:0] metric_p0;
  logic [CH_WIDTH-1:0]  chan_p0;
  logic                 take_p0;
  logic                 last_p0;
  logic                 pass_p0;

  logic [BUS_W-1:0]     nxt_data;
  logic [BUS_W-1:0]     nxt_abs;
  logic [ABS_WIDTH-1:0] nxt_metric;
  logic [IDX_WIDTH-1:0] nxt_idx;
  logic [CH_WIDTH-1:0]  nxt_chan;

  // Pad bits above ABS_WIDTH in each abs slot carry no magnitude information.
  logic unused_pad;
  assign unused_pad = ^s_axis_tdata_abs;

  // Stage p0: per-sample metric; strict compare keeps the lowest channel on ties.
  always_comb begin
    metric_p0 = '0;
    chan_p0   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (s_axis_tdata_abs[c*CHANNEL_WIDTH +: ABS_WIDTH] > metric_p0) begin
        metric_p0 = s_axis_tdata_abs[c*CHANNEL_WIDTH +: ABS_WIDTH];
        chan_p0   = CH_WIDTH'(c);
      end
    end
  end

  assign vld_p0  = s_axis_tvalid & s_axis_tready;
  assign take_p0 = (count == '0) || (metric_p0 > peak_metric_p1);
  assign last_p0 = (count == LAST);

  always_comb begin
    nxt_data   = peak_data_p1;
    nxt_abs    = peak_abs_p1;
    nxt_metric = peak_metric_p1;
    nxt_idx    = peak_idx_p1;
    nxt_chan   = peak_chan_p1;
    if (take_p0) begin
      nxt_data   = s_axis_tdata;
      nxt_abs    = s_axis_tdata_abs;
      nxt_metric = metric_p0;
      nxt_idx    = count;
      nxt_chan   = chan_p0;
    end
  end

`ifdef PEAK_THRESHOLD_EN
  assign pass_p0 = (nxt_metric >= threshold);
`else
  assign pass_p0 = 1'b1;
`endif

  // Stage p1: running peak and window control; output registers load at window end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= SCAN;
      count            <= '0;
      s_axis_tready    <= 1'b1;
      m_axis_tvalid    <= 1'b0;
      m_axis_tdata     <= '0;
      m_axis_tdata_abs <= '0;
      m_axis_tindex    <= '0;
      m_axis_tchan     <= '0;
      peak_data_p1     <= '0;
      peak_abs_p1      <= '0;
      peak_metric_p1   <= '0;
      peak_idx_p1      <= '0;
      peak_chan_p1     <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (vld_p0) begin
            peak_data_p1   <= nxt_data;
            peak_abs_p1    <= nxt_abs;
            peak_metric_p1 <= nxt_metric;
            peak_idx_p1    <= nxt_idx;
            peak_chan_p1   <= nxt_chan;
            if (last_p0) begin
              count <= '0;
              if (pass_p0) begin
                m_axis_tdata     <= nxt_data;
                m_axis_tdata_abs <= nxt_abs;
                m_axis_tindex    <= nxt_idx;
                m_axis_tchan     <= nxt_chan;
                m_axis_tvalid    <= 1'b1;
                s_axis_tready    <= 1'b0;
                state            <= OUT;
              end
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            state         <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
